sip_msg_packer: RTL and testbench
=================================

// Module: sip_msg_packer
// PURPOSE
// - Front end of the SipHash datapath, directly upstream of the compression rounds.
// - Takes a little-endian message as 64-bit beats with a byte count and a last flag.
// - Emits padded 64-bit message words m_i. The final word carries (msg_len mod 256) in bits [63:56].
// - Downstream sees only full 64-bit words, with m_last marking the final (length) word.
// PARAMETERS
// - LEN_W   64   width of the running byte-length counter; only len[7:0] enters the pad byte
// PORTS
// - clk        in   1      clock
// - rst        in   1      synchronous reset, active-high
// - s_data     in   64     message bytes, byte i at [8i+7:8i]
// - s_bytes    in   4      valid bytes in beat, 0..8, low bytes first; must be 8 unless s_last
// - s_last     in   1      last beat of message
// - s_valid    in   1      input beat valid
// - s_ready    out  1      packer can accept a beat
// - m_data     out  64     padded message word to compression stage
// - m_last     out  1      m_data is the final (length-carrying) word
// - m_len      out  LEN_W  total message byte count; valid when m_valid && m_last
// - m_valid    out  1      output word valid
// - m_ready    in   1      compression stage accepts word
// BEHAVIOUR
// - Reset: m_valid=0, m_data=0, m_last=0, m_len=0, len counter=0, state=ACCEPT. s_ready=1 in the cycle after reset.
// - Reset mid-message discards the partial message and the pending output.
// - Handshakes:
//   - Transfer occurs when valid&&ready on the same edge.
//   - m_* hold stable while m_valid && !m_ready.
// - Output register: single stage, 1-cycle latency from input accept to m_valid.
// - s_ready = (state==ACCEPT) && (!m_valid || m_ready). Same-cycle pop and push sustains full throughput.
// - Length counter: len += s_bytes on each accepted beat. Wraps modulo 2^LEN_W. Cleared when the final word is loaded.
// - Bytes at or above s_bytes are forced to 0 before padding. Upper data bytes are never passed through.
// - State ACCEPT, accepted beat:
//   - !s_last: m_data = s_data, m_last=0. A non-last beat with s_bytes!=8 is a protocol violation; it is counted as 8.
//   - s_last, s_bytes<8: m_data = masked data | (newlen[7:0]<<56), m_last=1, m_len=newlen. Stay in ACCEPT.
//   - s_last, s_bytes==8: m_data = s_data, m_last=0. Latch newlen into pad_len. Go to PAD.
// - State PAD: s_ready=0. When the output slot frees (!m_valid || m_ready):
//   - load m_data = pad_len[7:0]<<56, m_last=1, m_len=pad_len; go to ACCEPT.
// - Empty message (s_last, s_bytes=0, len=0): single word 0x00.., m_last=1, m_len=0.
// - s_bytes>8 is treated as 8.
// STRUCTURE
// - Package sip_pkg:
//   - SIP_WORD_W=64, SIP_BYTES_PER_WORD=8.
//   - sip_pack_state_t enum {ACCEPT, PAD}.
//   - Function sip_byte_mask(bytes) -> 64-bit keep mask.
// - One natural sub-module: sip_word_reg. It is the single-entry valid/ready output register (data, last, len) and is reusable by the finalization stage.
// - Packer = counter + 2-state FSM + masking/pad mux feeding sip_word_reg.
// TESTING
// - Empty msg: one beat s_bytes=0, s_last=1 -> one word 0x0000000000000000, m_last=1, m_len=0.
// - 15-byte msg 0x00..0x0e:
//   - 2 beats (8 bytes, then 7 bytes last).
//   - Words 0x0706050403020100 then 0x0F0E0D0C0B0A0908 with m_last=1.
//   - This matches the SipHash-2-4 reference vector input.
// - 8-byte msg, s_last on a full beat:
//   - First word = data with m_last=0, then 0x0800000000000000 with m_last=1.
//   - s_ready is low during PAD.
// - Backpressure: m_ready=0 for 5 cycles mid-stream -> m_* stable, s_ready=0, no beat lost/duplicated. Back-to-back throughput of 1 word/cycle when m_ready=1.
// - 300-byte msg (37 full beats + 4-byte last) -> final word pad byte 0x2C, m_len=300.
// - rst asserted while in PAD with m_valid=1 -> next cycle m_valid=0, state ACCEPT. A new 3-byte msg then yields len byte 0x03.

Source files
------------

// File: rtl/sip_msg_packer_pkg.sv
// Shared widths, packer state encoding and byte-keep mask helper for the SipHash front end.
// Pure definitions; no timing or flow-control behaviour of its own.
package sip_pkg;

    localparam int SIP_WORD_W         = 64;
    localparam int SIP_BYTES_PER_WORD = 8;

    typedef enum logic {
        ACCEPT = 1'b0,
        PAD    = 1'b1
    } sip_pack_state_t;

    // Keep mask with 0xFF in every byte lane below 'bytes'; counts above 8 keep all lanes.
    function automatic logic [SIP_WORD_W-1:0] sip_byte_mask(input logic [3:0] bytes);
        logic [SIP_WORD_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < SIP_BYTES_PER_WORD; i++) begin
            mask[8*i +: 8] = (4'(i) < bytes) ? 8'hFF : 8'h00;
        end
        return mask;
    endfunction

endpackage

// File: rtl/sip_msg_packer_word_reg.sv
// Single-entry valid/ready output register carrying one word, its last flag and length.
// Latency 1 cycle; accepts a new word in the same cycle the held one is taken.
module sip_word_reg
    import sip_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIP_WORD_W-1:0] in_data,
    input  logic                  in_last,
    input  logic [LEN_W-1:0]      in_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIP_WORD_W-1:0] out_data,
    output logic                  out_last,
    output logic [LEN_W-1:0]      out_len
);

    logic                  vld_q,  vld_d;
    logic [SIP_WORD_W-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic [LEN_W-1:0]      len_q,  len_d;
    logic                  load;

    always_comb begin
        in_ready = !vld_q || out_ready;
        load     = in_valid && in_ready;
        vld_d    = vld_q;
        data_d   = data_q;
        last_d   = last_q;
        len_d    = len_q;
        if (load) begin
            vld_d  = 1'b1;
            data_d = in_data;
            last_d = in_last;
            len_d  = in_len;
        end else if (out_ready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            len_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            len_q  <= len_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_len   = len_q;

endmodule

// File: rtl/sip_msg_packer.sv
// Packs little-endian message beats into padded SipHash words, length byte in the final word's top lane.
// Latency 1 cycle; s_ready drops when the output slot is held or a length-only word is pending.
module sip_msg_packer
    import sip_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIP_WORD_W-1:0] s_data,
    input  logic [3:0]            s_bytes,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [SIP_WORD_W-1:0] m_data,
    output logic                  m_last,
    output logic [LEN_W-1:0]      m_len,
    output logic                  m_valid,
    input  logic                  m_ready
);

    sip_pack_state_t       state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      pad_len_q, pad_len_d;

    logic                  slot_free;
    logic                  accept;
    logic [3:0]            eff_bytes;
    logic [LEN_W-1:0]      new_len;
    logic [SIP_WORD_W-1:0] masked;

    logic                  wr_vld;
    logic [SIP_WORD_W-1:0] wr_dat;
    logic                  wr_last;
    logic [LEN_W-1:0]      wr_len;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pad_len_d = pad_len_q;
        wr_vld    = 1'b0;
        wr_dat    = '0;
        wr_last   = 1'b0;
        wr_len    = '0;

        s_ready   = (state_q == ACCEPT) && slot_free;
        accept    = s_valid && s_ready;
        // Only a final beat may be short; anything else, or any count above 8, is a full word.
        eff_bytes = (s_last && (s_bytes < 4'd8)) ? s_bytes : 4'd8;
        new_len   = len_q + LEN_W'(eff_bytes);
        masked    = s_data & sip_byte_mask(eff_bytes);

        unique case (state_q)
            ACCEPT: begin
                if (accept) begin
                    wr_vld = 1'b1;
                    wr_len = new_len;
                    if (s_last && (eff_bytes < 4'd8)) begin
                        wr_dat  = masked | {new_len[7:0], 56'h0};
                        wr_last = 1'b1;
                        len_d   = '0;
                    end else if (s_last) begin
                        wr_dat    = masked;
                        pad_len_d = new_len;
                        len_d     = new_len;
                        state_d   = PAD;
                    end else begin
                        wr_dat = masked;
                        len_d  = new_len;
                    end
                end
            end
            PAD: begin
                if (slot_free) begin
                    wr_vld  = 1'b1;
                    wr_dat  = {pad_len_q[7:0], 56'h0};
                    wr_last = 1'b1;
                    wr_len  = pad_len_q;
                    len_d   = '0;
                    state_d = ACCEPT;
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCEPT;
            len_q     <= '0;
            pad_len_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pad_len_q <= pad_len_d;
        end
    end

    sip_word_reg #(.LEN_W(LEN_W)) u_word_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (wr_vld),
        .in_ready  (slot_free),
        .in_data   (wr_dat),
        .in_last   (wr_last),
        .in_len    (wr_len),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_last  (m_last),
        .out_len   (m_len)
    );

endmodule

// File: tb/tb_sip_msg_packer.sv
// Randomized scoreboard bench for sip_msg_packer: directed SipHash vectors plus random messages and stalls.
// Expected words come from a byte-array padding model; a monitor pops them on every output transfer.
module tb_sip_msg_packer;

    localparam int LEN_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       s_data;
    logic [3:0]        s_bytes;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;
    logic [63:0]       m_data;
    logic              m_last;
    logic [LEN_W-1:0]  m_len;
    logic              m_valid;
    logic              m_ready;

    always #5 clk = ~clk;

    sip_msg_packer #(.LEN_W(LEN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_bytes (s_bytes),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_len   (m_len),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [63:0] n;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  msg[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          rdy_mode = 2;
    int          stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Padding rule: message bytes, zero fill, then len mod 256 in the last byte of word floor(L/8).
    task automatic push_model();
        int   len;
        int   nw;
        exp_t e;
        len = msg.size();
        nw  = len / 8 + 1;
        for (int w = 0; w < nw; w++) begin
            e.d = '0;
            for (int b = 0; b < 8; b++) begin
                if (w * 8 + b < len) e.d[8*b +: 8] = msg[w * 8 + b];
            end
            if (w == nw - 1) e.d[63:56] = 8'(len);
            e.l = (w == nw - 1);
            e.n = 64'(len);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [3:0] nb, input logic lst,
                              output bit waited);
        s_data  = d;
        s_bytes = nb;
        s_last  = lst;
        s_valid = 1'b1;
        waited  = 1'b0;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (s_ready) break;
            waited = 1'b1;
            if (t > 1000) begin
                $display("FAIL s_ready_timeout: got 0 want 1 within 1000 cycles");
                n_fail++;
                $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
                $fatal(1, "input stalled");
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = '0;
        s_bytes = '0;
        s_last  = 1'b0;
    endtask

    task automatic send_msg(input bit garbage, input bit big, input bit gaps,
                            input bit thru, input bit model);
        int          len;
        int          nb;
        int          cnt;
        logic [63:0] d;
        logic [3:0]  sb;
        bit          lst;
        bit          waited;
        if (model) push_model();
        len = msg.size();
        nb  = (len == 0) ? 1 : (len + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            cnt = (len - 8 * k > 8) ? 8 : len - 8 * k;
            lst = (k == nb - 1);
            d   = garbage ? {$urandom, $urandom} : 64'h0;
            for (int b = 0; b < cnt; b++) d[8*b +: 8] = msg[8 * k + b];
            sb = 4'(cnt);
            if (lst && cnt == 8 && big) sb = 4'($urandom_range(9, 15));
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin
                @(posedge clk); #1;
            end
            drive_beat(d, sb, lst, waited);
            if (thru) chk("thru_no_wait", 64'(waited), 64'h0);
            if (lst && cnt == 8) begin
                @(negedge clk);
                chk("pad_s_ready_low", 64'(s_ready), 64'h0);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic fill_rand(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic drain();
        for (int t = 0; exp_q.size() != 0; t++) begin
            if (t > 3000) begin
                chk("drain_left", 64'(exp_q.size()), 64'h0);
                exp_q.delete();
                break;
            end
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_bytes = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        fork
            begin : stimulus
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("rst_m_valid", 64'(m_valid), 64'h0);
                chk("rst_m_data", m_data, 64'h0);
                chk("rst_m_last", 64'(m_last), 64'h0);
                chk("rst_m_len", m_len, 64'h0);
                chk("rst_s_ready", 64'(s_ready), 64'h1);
                @(posedge clk); #1;

                rdy_mode = 1;
                msg.delete();
                send_msg(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                msg.delete();
                for (int i = 0; i < 15; i++) msg.push_back(8'(i));
                send_msg(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                fill_rand(8);
                send_msg(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                repeat (2) begin
                    @(posedge clk); #1;
                end
                fill_rand(37);
                send_msg(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

                rdy_mode = 0;
                fill_rand(300);
                send_msg(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
                for (int m = 0; m < 40; m++) begin
                    fill_rand($urandom_range(0, 40));
                    send_msg(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
                end
                drain();

                // Reset while a length-only word is pending and the output word is held.
                rdy_mode = 2;
                repeat (2) begin
                    @(posedge clk); #1;
                end
                fill_rand(8);
                send_msg(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("pad_m_valid", 64'(m_valid), 64'h1);
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("midrst_m_valid", 64'(m_valid), 64'h0);
                chk("midrst_s_ready", 64'(s_ready), 64'h1);
                chk("midrst_m_last", 64'(m_last), 64'h0);
                @(posedge clk); #1;
                rdy_mode = 0;
                fill_rand(3);
                send_msg(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                drain();

                $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
                $finish;
            end
            begin : monitor
                exp_t        e;
                bit          hold_v;
                logic [63:0] hd;
                logic        hl;
                logic [63:0] hn;
                hold_v = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        hold_v = 1'b0;
                    end else begin
                        if (hold_v) begin
                            chk("hold_m_valid", 64'(m_valid), 64'h1);
                            chk("hold_m_data", m_data, hd);
                            chk("hold_m_last", 64'(m_last), 64'(hl));
                            chk("hold_m_len", m_len, hn);
                        end
                        if (m_valid && !m_ready) chk("stall_s_ready", 64'(s_ready), 64'h0);
                        if (m_valid && m_ready) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_word", m_data, 64'hxxxxxxxxxxxxxxxx);
                            end else begin
                                e = exp_q.pop_front();
                                chk("m_data", m_data, e.d);
                                chk("m_last", 64'(m_last), 64'(e.l));
                                if (e.l) chk("m_len", m_len, e.n);
                            end
                        end
                        hold_v = m_valid && !m_ready;
                        hd = m_data;
                        hl = m_last;
                        hn = m_len;
                    end
                end
            end
            begin : ready_gen
                forever begin
                    @(posedge clk); #1;
                    if (rdy_mode == 1) begin
                        m_ready = 1'b1;
                    end else if (rdy_mode == 2) begin
                        m_ready = 1'b0;
                    end else if (stall > 0) begin
                        m_ready = 1'b0;
                        stall--;
                    end else if ($urandom_range(0, 15) == 0) begin
                        m_ready = 1'b0;
                        stall = 4;
                    end else begin
                        m_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            end
        join
    end

endmodule
